// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor
//
// Receive-side checker for a counter/d stream. On every clock it compares the
// sampled counter with the value implied by the previous sample:
//    previous d high -> counter must be previous counter + 1 (wrapping)
//    previous d low  -> counter must be unchanged
// After LOCK_CYCLES consecutive clean steps the monitor locks. While locked,
// each bad step is flagged, counted and drops the monitor back to resync.
//
// Ports
//    clk         rising-edge clock
//    rst         synchronous active-high reset
//    counter     observed counter value (CNT_W bits)
//    d           advance qualifier for the next step
//    clear       synchronous clear of err_sticky / err_count (FSM unaffected)
//    locked      high while the FSM is in LOCKED
//    err_pulse   one-cycle pulse per violation seen while locked
//    err_sticky  set on any violation, held until clear or rst
//    err_count   saturating violation counter (ERR_W bits)
//    wrap_pulse  one-cycle pulse on a clean all-ones -> zero step while locked
//
// Optional build macro: CNT_MON_CAPTURE_EN
//    When defined, adds bad_seen / bad_exp outputs holding the observed and
//    expected counter values of the most recent violation. Without the macro
//    these ports and their registers do not exist.
//
// All outputs are registered, so every decision shows up one cycle after the
// sample that caused it.
// ---------------------------------------------------------------------------
module count_monitor #(
   parameter int CNT_W       = 5,
   parameter int LOCK_CYCLES = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] counter,
   input  logic             d,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic             wrap_pulse
`ifdef CNT_MON_CAPTURE_EN
   ,
   output logic [CNT_W-1:0] bad_seen,
   output logic [CNT_W-1:0] bad_exp
`endif
);

   // good_cnt must be able to hold the value LOCK_CYCLES itself
   localparam int GW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
   localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [GW-1:0]    good_cnt;
   logic [GW-1:0]    good_cnt_next;
   logic [CNT_W-1:0] prev_cnt;
   logic             prev_d;

   logic [CNT_W-1:0] expected;
   logic             good;
   logic             prev_all_ones;

   logic             err_event;
   logic             wrap_event;
   logic             err_sticky_next;
   logic [ERR_W-1:0] err_count_next;

   // The value the counter should show this cycle, derived only from the
   // previous sample. Wrapping falls out of the CNT_W-bit truncation.
   assign expected      = prev_d ? (prev_cnt + CNT_W'(1)) : prev_cnt;
   assign good          = (counter == expected);
   assign prev_all_ones = (prev_cnt == {CNT_W{1'b1}});

   // Next-state logic. IDLE only exists to take a first sample that has no
   // predecessor, so no check happens there. In SYNC a bad step silently
   // restarts the run of good steps; only LOCKED reports violations.
   always_comb begin
      state_next    = state;
      good_cnt_next = good_cnt;
      err_event     = 1'b0;
      wrap_event    = 1'b0;

      case (state)
         IDLE: begin
            state_next    = SYNC;
            good_cnt_next = '0;
         end

         SYNC: begin
            if (good) begin
               if (good_cnt >= (LOCK_TARGET - GW'(1))) begin
                  state_next    = LOCKED;
                  good_cnt_next = LOCK_TARGET;
               end else begin
                  good_cnt_next = good_cnt + GW'(1);
               end
            end else begin
               good_cnt_next = '0;
            end
         end

         LOCKED: begin
            if (good) begin
               wrap_event = prev_d && prev_all_ones;
            end else begin
               err_event     = 1'b1;
               state_next    = SYNC;
               good_cnt_next = '0;
            end
         end

         default: begin
            state_next    = IDLE;
            good_cnt_next = '0;
         end
      endcase
   end

   // Error bookkeeping. A violation in the same cycle as clear takes priority
   // so the violation is never lost: the count restarts at one rather than
   // zero. The counter saturates instead of wrapping so a flood of errors can
   // never read back as a small number.
   always_comb begin
      err_sticky_next = err_sticky;
      err_count_next  = err_count;

      if (err_event) begin
         err_sticky_next = 1'b1;
         if (clear) begin
            err_count_next = ERR_W'(1);
         end else if (err_count != {ERR_W{1'b1}}) begin
            err_count_next = err_count + ERR_W'(1);
         end
      end else if (clear) begin
         err_sticky_next = 1'b0;
         err_count_next  = '0;
      end
   end

   // State register and sample history. The history always follows the
   // observed stream, so after a bad step the monitor resynchronises to what
   // it actually saw rather than to what it expected.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         good_cnt <= '0;
         prev_cnt <= '0;
         prev_d   <= 1'b0;
      end else begin
         state    <= state_next;
         good_cnt <= good_cnt_next;
         prev_cnt <= counter;
         prev_d   <= d;
      end
   end

   // Registered outputs. locked tracks the next state so it rises and falls
   // on the same edge that the FSM enters or leaves LOCKED.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         locked     <= (state_next == LOCKED);
         err_pulse  <= err_event;
         wrap_pulse <= wrap_event;
         err_sticky <= err_sticky_next;
         err_count  <= err_count_next;
      end
   end

`ifdef CNT_MON_CAPTURE_EN
   // Snapshot of the most recent violation. Like the error counter, a
   // violation coinciding with clear still loads the snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         bad_seen <= '0;
         bad_exp  <= '0;
      end else if (err_event) begin
         bad_seen <= counter;
         bad_exp  <= expected;
      end else if (clear) begin
         bad_seen <= '0;
         bad_exp  <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_monitor
//
// Drives count_monitor with directed scenarios followed by a long randomized
// stream of mostly-legal counter steps with injected violations, clears and
// resets. A behavioural model tracks what the monitor must report and a
// compare process checks every output each cycle; a few literal expectations
// pin the model on the directed scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_count_monitor;

   localparam int CNT_W       = 5;
   localparam int LOCK_CYCLES = 4;
   localparam int ERR_W       = 8;
   localparam int CNT_MASK    = (1 << CNT_W) - 1;
   localparam int ERR_MAX     = (1 << ERR_W) - 1;

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] counter;
   logic             d;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic             err_sticky;
   logic [ERR_W-1:0] err_count;
   logic             wrap_pulse;
`ifdef CNT_MON_CAPTURE_EN
   logic [CNT_W-1:0] bad_seen;
   logic [CNT_W-1:0] bad_exp;
`endif

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   bit model_valid = 0;
   bit m_fresh     = 1;
   int m_prev      = 0;
   int m_prevd     = 0;
   int m_run       = 0;
   bit m_lock      = 0;
   bit m_ep        = 0;
   bit m_wp        = 0;
   bit m_sticky    = 0;
   int m_count     = 0;
   int m_seen      = 0;
   int m_expv      = 0;

   // Last values driven, used to build legal and illegal next steps
   int cur_cnt = 0;
   int cur_d   = 0;

   count_monitor #(
      .CNT_W      (CNT_W),
      .LOCK_CYCLES(LOCK_CYCLES),
      .ERR_W      (ERR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .counter   (counter),
      .d         (d),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_sticky(err_sticky),
      .err_count (err_count),
      .wrap_pulse(wrap_pulse)
`ifdef CNT_MON_CAPTURE_EN
      ,
      .bad_seen  (bad_seen),
      .bad_exp   (bad_exp)
`endif
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point shared by the compare process and the directed
   // literal expectations.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model of the monitor from its rules: first sample after reset is
   // unchecked, LOCK_CYCLES clean steps lock it, a bad step while locked is
   // a reported violation and restarts the run.
   task automatic modelStep();
      int exp_v;
      bit ok;
      if (rst) begin
         model_valid = 1;
         m_fresh  = 1;
         m_prev   = 0;
         m_prevd  = 0;
         m_run    = 0;
         m_lock   = 0;
         m_ep     = 0;
         m_wp     = 0;
         m_sticky = 0;
         m_count  = 0;
         m_seen   = 0;
         m_expv   = 0;
      end else begin
         exp_v = (m_prevd != 0) ? ((m_prev + 1) & CNT_MASK) : m_prev;
         ok    = (int'(counter) == exp_v);
         m_ep  = 0;
         m_wp  = 0;
         if (m_fresh) begin
            m_fresh = 0;
         end else if (!m_lock) begin
            if (ok) begin
               m_run++;
               if (m_run >= LOCK_CYCLES) m_lock = 1;
            end else begin
               m_run = 0;
            end
         end else if (ok) begin
            m_wp = (m_prevd != 0) && (m_prev == CNT_MASK);
         end else begin
            m_ep   = 1;
            m_lock = 0;
            m_run  = 0;
         end
         if (m_ep) begin
            m_sticky = 1;
            m_count  = clear ? 1 : ((m_count < ERR_MAX) ? m_count + 1 : ERR_MAX);
            m_seen   = int'(counter);
            m_expv   = exp_v;
         end else if (clear) begin
            m_sticky = 0;
            m_count  = 0;
            m_seen   = 0;
            m_expv   = 0;
         end
         m_prev  = int'(counter);
         m_prevd = int'(d);
      end
   endtask

   // One clock of stimulus: drive on the falling edge, advance the model at
   // the rising edge, return just after it.
   task automatic applyStimulus(input int cnt, input int dv, input bit clr, input bit rs);
      @(negedge clk);
      counter = CNT_W'(cnt);
      d       = dv[0];
      clear   = clr;
      rst     = rs;
      cur_cnt = cnt & CNT_MASK;
      cur_d   = dv & 1;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic goodStep(input int dv, input bit clr);
      applyStimulus((cur_d != 0) ? ((cur_cnt + 1) & CNT_MASK) : cur_cnt, dv, clr, 1'b0);
   endtask

   task automatic badStep(input int dv, input bit clr);
      int e;
      e = (cur_d != 0) ? ((cur_cnt + 1) & CNT_MASK) : cur_cnt;
      applyStimulus((e + int'($urandom_range(1, CNT_MASK))) & CNT_MASK, dv, clr, 1'b0);
   endtask

   // Compare process: every falling edge once a reset has been modelled
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("cmp_locked",     int'(locked),     int'(m_lock));
         checkOutput("cmp_err_pulse",  int'(err_pulse),  int'(m_ep));
         checkOutput("cmp_err_sticky", int'(err_sticky), int'(m_sticky));
         checkOutput("cmp_err_count",  int'(err_count),  m_count);
         checkOutput("cmp_wrap_pulse", int'(wrap_pulse), int'(m_wp));
`ifdef CNT_MON_CAPTURE_EN
         checkOutput("cmp_bad_seen",   int'(bad_seen),   m_seen);
         checkOutput("cmp_bad_exp",    int'(bad_exp),    m_expv);
`endif
      end
   end

   initial begin
      int wraps;
      int r;
      rst     = 1'b1;
      counter = '0;
      d       = 1'b0;
      clear   = 1'b0;

      // Reset edge, then counter 0,1,2,... with d high. Counting the reset
      // edge as the first, locked rises on the sixth edge.
      applyStimulus(0, 1, 1'b0, 1'b1);
      checkOutput("t1_reset_locked", int'(locked), 0);
      checkOutput("t1_reset_count", int'(err_count), 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i, 1, 1'b0, 1'b0);
         checkOutput("t1_lock_edge", int'(locked), (i == 4) ? 1 : 0);
      end
      checkOutput("t1_err_count", int'(err_count), 0);

      // Run through 30, 31, 0, 1: exactly one wrap pulse, after 0 is sampled
      wraps = 0;
      for (int v = 5; v <= 33; v++) begin
         applyStimulus(v & CNT_MASK, 1, 1'b0, 1'b0);
         wraps += int'(wrap_pulse);
         if (v == 32) checkOutput("t2_wrap_after_zero", int'(wrap_pulse), 1);
      end
      checkOutput("t2_wrap_once", wraps, 1);

      // Locked at 10, then 12 instead of 11
      for (int v = 2; v <= 10; v++) applyStimulus(v, 1, 1'b0, 1'b0);
      applyStimulus(12, 1, 1'b0, 1'b0);
      checkOutput("t3_err_pulse", int'(err_pulse), 1);
      checkOutput("t3_err_count", int'(err_count), 1);
      checkOutput("t3_unlocked", int'(locked), 0);
`ifdef CNT_MON_CAPTURE_EN
      checkOutput("t3_bad_seen", int'(bad_seen), 12);
      checkOutput("t3_bad_exp", int'(bad_exp), 11);
`endif
      applyStimulus(13, 1, 1'b0, 1'b0);
      checkOutput("t3_pulse_one_cycle", int'(err_pulse), 0);
      applyStimulus(14, 1, 1'b0, 1'b0);
      applyStimulus(15, 1, 1'b0, 1'b0);
      checkOutput("t3_not_yet_relocked", int'(locked), 0);
      applyStimulus(16, 1, 1'b0, 1'b0);
      checkOutput("t3_relocked", int'(locked), 1);

      // d low: counter must hold; a change is a violation
      applyStimulus(17, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(17, 0, 1'b0, 1'b0);
         checkOutput("t4_hold_no_err", int'(err_pulse), 0);
      end
      checkOutput("t4_hold_count", int'(err_count), 1);
      applyStimulus(18, 0, 1'b0, 1'b0);
      checkOutput("t4_change_err", int'(err_pulse), 1);
      checkOutput("t4_change_count", int'(err_count), 2);

      // 300 violations: saturate at 255, then clear alone
      for (int k = 0; k < 300; k++) begin
         for (int g = 0; g < LOCK_CYCLES; g++) goodStep(int'($urandom_range(0, 1)), 1'b0);
         badStep(int'($urandom_range(0, 1)), 1'b0);
      end
      checkOutput("t5_sat_count", int'(err_count), 255);
      checkOutput("t5_sat_sticky", int'(err_sticky), 1);
      checkOutput("t5_sat_pulse", int'(err_pulse), 1);
      goodStep(1, 1'b1);
      checkOutput("t5_clear_count", int'(err_count), 0);
      checkOutput("t5_clear_sticky", int'(err_sticky), 0);

      // Clear together with a violation: the violation wins
      for (int g = 0; g < LOCK_CYCLES; g++) goodStep(1, 1'b0);
      checkOutput("t6_locked_before", int'(locked), 1);
      badStep(1, 1'b1);
      checkOutput("t6_clear_err_count", int'(err_count), 1);
      checkOutput("t6_clear_err_sticky", int'(err_sticky), 1);
      checkOutput("t6_clear_err_pulse", int'(err_pulse), 1);

      // Reset while locked
      for (int g = 0; g < LOCK_CYCLES + 1; g++) goodStep(1, 1'b0);
      checkOutput("t6_relocked", int'(locked), 1);
      applyStimulus(int'($urandom_range(0, CNT_MASK)), 1, 1'b0, 1'b1);
      checkOutput("t6_rst_locked", int'(locked), 0);
      checkOutput("t6_rst_count", int'(err_count), 0);
      checkOutput("t6_rst_sticky", int'(err_sticky), 0);

      // Randomized stream
      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 999));
         if (r < 5) begin
            applyStimulus(int'($urandom_range(0, CNT_MASK)), int'($urandom_range(0, 1)), 1'b0, 1'b1);
         end else if (r < 45) begin
            badStep(int'($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 3));
         end else begin
            goodStep(int'($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 3));
         end
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
